branch_predictor_btb: RTL

Parametrised successor to the core's single-entry branch predictor: a direct-mapped branch target buffer with per-entry saturating counters and an optional global-history (gshare) index. It sits beside `instructionfetch`, answers a same-cycle lookup for the fetch address, and takes resolution updates from the execute stage. On a misprediction it issues a registered one-cycle redirect to fetch and the flush path.

---
 rtl/bp_pkg.sv | 35 +++
 rtl/bp_sat_ctr.sv | 27 ++
 rtl/branch_predictor_btb.sv | 131 +++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch target buffer: operating modes and
// width-generic saturating counter helpers.
package bp_pkg;

  typedef enum logic {
    BP_BIMODAL = 1'b0,
    BP_GSHARE  = 1'b1
  } bp_mode_e;

  localparam int STAT_W    = 16;
  localparam int CTR_MAX_W = 3;

  typedef logic [CTR_MAX_W-1:0] ctr_t;

  function automatic ctr_t ctrMax(input int w);
    return ctr_t'((1 << w) - 1);
  endfunction

  function automatic ctr_t satInc(input ctr_t c, input int w);
    return (c == ctrMax(w)) ? c : c + ctr_t'(1);
  endfunction

  function automatic ctr_t satDec(input ctr_t c);
    return (c == ctr_t'(0)) ? c : c - ctr_t'(1);
  endfunction

  function automatic ctr_t weaklyTaken(input int w);
    return ctr_t'(1 << (w - 1));
  endfunction

  function automatic ctr_t weaklyNotTaken(input int w);
    return ctr_t'((1 << (w - 1)) - 1);
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Event counter that sticks at all-ones instead of wrapping.
module bp_sat_ctr
  import bp_pkg::*;
#(
  parameter int W = STAT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with saturating direction counters, optional gshare
// indexing, registered mispredict redirect and lookup/mispredict statistics.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int HIST_W  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       lk_valid,
  input  logic [ADDR_W-1:0]          lk_pc,
  output logic                       pred_hit,
  output logic                       pred_taken,
  output logic [ADDR_W-1:0]          pred_target,
  output logic [$clog2(ENTRIES)-1:0] pred_idx,
  input  logic                       up_valid,
  input  logic [ADDR_W-1:0]          up_pc,
  input  logic [$clog2(ENTRIES)-1:0] up_idx,
  input  logic                       up_taken,
  input  logic [ADDR_W-1:0]          up_target,
  input  logic                       up_pred_taken,
  input  logic [ADDR_W-1:0]          up_pred_target,
  output logic                       redirect,
  output logic [ADDR_W-1:0]          redirect_pc,
  output logic [STAT_W-1:0]          stat_lookups,
  output logic [STAT_W-1:0]          stat_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int GHR_W = (HIST_W > 0) ? HIST_W : 1;
  localparam bp_mode_e MODE = (HIST_W > 0) ? BP_GSHARE : BP_BIMODAL;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [CTR_W-1:0]  ctr_q    [ENTRIES];

  logic [GHR_W-1:0]  ghr_q, ghr_d;
  logic              redirect_q, redirect_d;
  logic [ADDR_W-1:0] redirectPc_q, redirectPc_d;

  logic [IDX_W-1:0]  lkIdx;
  logic [TAG_W-1:0]  lkTag, upTag;
  logic              upHit, mispredict;
  logic [CTR_W-1:0]  ctrInc, ctrDec;

  // Lookup reads only registered state, so a same-cycle update is invisible here.
  always_comb begin
    lkIdx       = lk_pc[IDX_W-1:0] ^ IDX_W'(ghr_q);
    lkTag       = lk_pc[ADDR_W-1:IDX_W];
    pred_hit    = valid_q[lkIdx] && (tag_q[lkIdx] == lkTag);
    pred_taken  = pred_hit && ctr_q[lkIdx][CTR_W-1];
    pred_target = pred_taken ? target_q[lkIdx] : lk_pc + ADDR_W'(1);
    pred_idx    = lkIdx;
  end

  always_comb begin
    upTag      = up_pc[ADDR_W-1:IDX_W];
    upHit      = valid_q[up_idx] && (tag_q[up_idx] == upTag);
    mispredict = up_valid && ((up_pred_taken != up_taken) ||
                              (up_taken && (up_pred_target != up_target)));
    ctrInc     = CTR_W'(satInc(ctr_t'(ctr_q[up_idx]), CTR_W));
    ctrDec     = CTR_W'(satDec(ctr_t'(ctr_q[up_idx])));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_W'(weaklyNotTaken(CTR_W));
      end
    end else if (up_valid) begin
      if (upHit) begin
        ctr_q[up_idx] <= up_taken ? ctrInc : ctrDec;
      end else if (up_taken) begin
        valid_q[up_idx] <= 1'b1;
        ctr_q[up_idx]   <= CTR_W'(weaklyTaken(CTR_W));
      end
    end
  end

  // Tags and targets carry no reset; the cleared valid bits hide them.
  always_ff @(posedge clk) begin
    if (reset && up_valid && up_taken) begin
      target_q[up_idx] <= up_target;
      if (!upHit) tag_q[up_idx] <= upTag;
    end
  end

  always_comb begin
    ghr_d        = ghr_q;
    redirect_d   = mispredict;
    redirectPc_d = redirectPc_q;
    if (up_valid && (MODE == BP_GSHARE)) ghr_d = GHR_W'({ghr_q, up_taken});
    if (mispredict) redirectPc_d = up_taken ? up_target : up_pc + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ghr_q        <= '0;
      redirect_q   <= 1'b0;
      redirectPc_q <= '0;
    end else begin
      ghr_q        <= ghr_d;
      redirect_q   <= redirect_d;
      redirectPc_q <= redirectPc_d;
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirectPc_q;

  bp_sat_ctr #(.W(STAT_W)) lookupCtr (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (lk_valid),
    .count_o (stat_lookups)
  );

  bp_sat_ctr #(.W(STAT_W)) mispredCtr (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (mispredict),
    .count_o (stat_mispred)
  );

endmodule
